char_check: RTL and testbench
=============================

// Module: char_check
// PURPOSE
// - Serial ASCII-character pattern checker: consumes one 8-bit character per clk.
// - Flags when the stream since the last break is an alternating '1'/'0' string that
//   starts and ends with '1' and is at least MIN_LEN characters long ("101", "10101", ...).
// - Sits behind a byte source such as a UART RX or a test driver; out is a registered level flag.
// PARAMETERS
// - MIN_LEN  3  minimum run length, in characters, for out to assert (must be >= 1, odd values meaningful)
// - CNT_W    8  width of the run-length counter; counter saturates at 2**CNT_W-1
// PORTS
// - clk    in   1  single clock; all state updates on posedge
// - reset  in   1  synchronous, active-high reset
// - in     in   8  ASCII character sampled every posedge
// - out    out  1  pattern-match flag, registered (Moore)
// - Interface: one clock; reset is synchronous and active-high.
// BEHAVIOUR
// - Character classes: 8'h31 ('1') = ONE; 8'h30 ('0') = ZERO; any other value = OTHER.
// - State: active (1b), last (1b, last accepted bit), len (CNT_W, run length).
// - Reset (sampled at posedge): active=0, last=0, len=0, out=0. Reset overrides the in value.
// - Per posedge, not in reset:
//   - ONE  & active & last==0 : len<=sat(len+1), last<=1.
//   - ONE  otherwise          : new run: active<=1, len<=1, last<=1.
//   - ZERO & active & last==1 : len<=sat(len+1), last<=0.
//   - ZERO otherwise          : active<=0, len<=0 (run broken; "00" or leading '0').
//   - OTHER                   : active<=0, len<=0, last<=0.
// - out <= next_active & next_last & (next_len >= MIN_LEN); i.e. out reflects the
//   character sampled at the same edge; latency 1 clk from in to out.
// - "11": second '1' restarts the run at len=1 (out deasserts, may reassert later).
// - Saturation: len holds at max; pattern keeps matching, out stays valid indefinitely.
// - No handshake; every cycle's in is consumed. in must be stable around posedge.
// STRUCTURE
// - Shared package: localparams CHAR_ZERO=8'h30, CHAR_ONE=8'h31; enum class_t {CLS_ZERO,CLS_ONE,CLS_OTHER}.
// - One natural sub-module: char_classify (combinational in[7:0] -> class_t).
// - Top: state registers + next-state logic + registered out compare.
// TESTING
// - Reset held 2 clk with in="1" -> out=0, len=0 after release edge.
// - Drive "1","0","1","0","1" one per clk -> out after each edge: 0,0,1,0,1.
// - "1","0","1","1" -> out 0,0,1,0 (double '1' restarts, len=1).
// - "1","0","1","A","1" -> out 0,0,1,0,0 (OTHER breaks run).
// - "0","0","1","0","1" -> out 0,0,0,0,1 (leading zeros ignored, run starts at '1').
// - CNT_W=2, 9 alternating chars from '1' -> len saturates at 3, out=1 after each '1', 0 after each '0'; reset mid-run -> out=0 next edge.

Source files
------------

// File: rtl/char_check_pkg.sv
// Shared character codes and class encoding for the
// serial '1'/'0' alternating-run checker.
package char_check_pkg;

  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_ONE  = 8'h31;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_ONE,
    CLS_OTHER
  } class_t;

endpackage

// File: rtl/char_check_classify.sv
// Combinational ASCII character classifier:
// maps a byte to ZERO, ONE or OTHER.
module char_check_classify
  import char_check_pkg::*;
(
  input  logic [7:0] in,
  output class_t     cls
);

  always_comb begin
    cls = CLS_OTHER;
    unique case (1'b1)
      (in == CHAR_ZERO): cls = CLS_ZERO;
      (in == CHAR_ONE):  cls = CLS_ONE;
      default:           cls = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/char_check.sv
// Flags an alternating "1010...1" run of at least
// MIN_LEN characters since the last break; out is registered.
module char_check
  import char_check_pkg::*;
#(
  parameter int MIN_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  output logic       out
);

  class_t           cls;
  logic             active;
  logic             last;
  logic [CNT_W-1:0] len;
  logic             next_active;
  logic             next_last;
  logic [CNT_W-1:0] next_len;
  logic [CNT_W-1:0] len_inc;
  logic             next_out;

  char_check_classify u_classify (
    .in  (in),
    .cls (cls)
  );

  // Run length holds at all-ones so long runs keep matching.
  assign len_inc = (len == {CNT_W{1'b1}}) ? len : len + 1'b1;

  always_comb begin
    next_active = active;
    next_last   = last;
    next_len    = len;
    unique case (cls)
      CLS_ONE: begin
        next_active = 1'b1;
        next_last   = 1'b1;
        next_len    = (active && !last) ? len_inc : CNT_W'(1);
      end
      CLS_ZERO: begin
        if (active && last) begin
          next_len  = len_inc;
          next_last = 1'b0;
        end else begin
          next_active = 1'b0;
          next_len    = '0;
        end
      end
      default: begin
        next_active = 1'b0;
        next_last   = 1'b0;
        next_len    = '0;
      end
    endcase
  end

  assign next_out = next_active && next_last &&
                    (32'(next_len) >= MIN_LEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      last   <= 1'b0;
      len    <= '0;
      out    <= 1'b0;
    end else begin
      active <= next_active;
      last   <= next_last;
      len    <= next_len;
      out    <= next_out;
    end
  end

endmodule

// File: tb/tb_char_check.sv
// Directed-vector bench for char_check: default
// instance plus a CNT_W=2 instance for saturation.
module tb_char_check;

  logic       clk;
  logic       reset;
  logic [7:0] in;
  logic       out;
  logic       reset2;
  logic [7:0] in2;
  logic       out2;

  int tests;
  int fails;

  char_check dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  char_check #(.MIN_LEN(3), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset2),
    .in    (in2),
    .out   (out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [7:0] c);
    @(negedge clk);
    in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic brk();
    step("X");
    tests++;
    if (out !== 1'b0) begin
      fails++;
      $display("FAIL break: out=%b expected 0", out);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    in    = "1";
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (out !== 1'b0 || dut.len !== 8'd0) begin
        fails++;
        $display("FAIL reset%0d: out=%b len=%0d expected out=0 len=0",
                 i, out, dut.len);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    in    = "X";
  endtask

  task automatic test_alternating();
    logic [7:0] c [5] = '{"1", "0", "1", "0", "1"};
    logic       e [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    brk();
    for (int i = 0; i < 5; i++) begin
      step(c[i]);
      tests++;
      if (out !== e[i]) begin
        fails++;
        $display("FAIL alternating step %0d: out=%b expected %b",
                 i, out, e[i]);
      end
    end
  endtask

  task automatic test_double_one();
    logic [7:0] c [4] = '{"1", "0", "1", "1"};
    logic       e [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    brk();
    for (int i = 0; i < 4; i++) begin
      step(c[i]);
      tests++;
      if (out !== e[i]) begin
        fails++;
        $display("FAIL double_one step %0d: out=%b expected %b",
                 i, out, e[i]);
      end
    end
    tests++;
    if (dut.len !== 8'd1) begin
      fails++;
      $display("FAIL double_one len: len=%0d expected 1", dut.len);
    end
  endtask

  task automatic test_other_break();
    logic [7:0] c [5] = '{"1", "0", "1", "A", "1"};
    logic       e [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    brk();
    for (int i = 0; i < 5; i++) begin
      step(c[i]);
      tests++;
      if (out !== e[i]) begin
        fails++;
        $display("FAIL other_break step %0d: out=%b expected %b",
                 i, out, e[i]);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [7:0] c [5] = '{"0", "0", "1", "0", "1"};
    logic       e [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    brk();
    for (int i = 0; i < 5; i++) begin
      step(c[i]);
      tests++;
      if (out !== e[i]) begin
        fails++;
        $display("FAIL leading_zero step %0d: out=%b expected %b",
                 i, out, e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] c [7] = '{"1", "0", "0", "1", "0", "1", "0"};
    logic       e [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    brk();
    for (int i = 0; i < 7; i++) begin
      step(c[i]);
      tests++;
      if (out !== e[i]) begin
        fails++;
        $display("FAIL back_to_back step %0d: out=%b expected %b",
                 i, out, e[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] el [9] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3,
                           2'd3, 2'd3, 2'd3, 2'd3};
    logic       e;
    @(negedge clk);
    reset2 = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset2 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in2 = (i % 2 == 0) ? 8'h31 : 8'h30;
      @(posedge clk);
      #1;
      e = (i % 2 == 0) && (i >= 2);
      tests++;
      if (out2 !== e || dut2.len !== el[i]) begin
        fails++;
        $display("FAIL saturation step %0d: out=%b len=%0d expected out=%b len=%0d",
                 i, out2, dut2.len, e, el[i]);
      end
    end
    @(negedge clk);
    reset2 = 1'b1;
    in2    = 8'h30;
    @(posedge clk);
    #1;
    tests++;
    if (out2 !== 1'b0 || dut2.len !== 2'd0) begin
      fails++;
      $display("FAIL mid_run_reset: out=%b len=%0d expected out=0 len=0",
               out2, dut2.len);
    end
    @(negedge clk);
    reset2 = 1'b0;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    reset  = 1'b1;
    in     = "X";
    reset2 = 1'b1;
    in2    = "X";
    test_reset();
    test_alternating();
    test_double_one();
    test_other_break();
    test_leading_zero();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
